ctrl_pipe_decoder: RTL and testbench

CTRL_PIPE_DECODER -- requirements
Module: ctrl_pipe_decoder

---
 rtl/ctrl_pkg.sv | 88 ++++++++
 rtl/ctrl_decode.sv | 77 +++++++
 rtl/ctrl_pipe_decoder.sv | 112 +++++++++++
 tb/tb_ctrl_pipe_decoder.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// ctrl_pkg
// Shared definitions for the pipelined control decoder: opcode constants,
// field encodings, the decoded control bundle and the per-stage register
// layouts carried down the pipe.
package ctrl_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef enum logic [2:0] {
        IMM_I = 3'b000,
        IMM_S = 3'b001,
        IMM_B = 3'b010,
        IMM_J = 3'b011,
        IMM_U = 3'b100
    } imm_src_t;

    typedef enum logic [1:0] {
        RES_ALU = 2'b00,
        RES_MEM = 2'b01,
        RES_PC4 = 2'b10
    } result_src_t;

    typedef enum logic [1:0] {
        ALU_A_RS1  = 2'b00,
        ALU_A_ZERO = 2'b01,
        ALU_A_PC   = 2'b10
    } alu_a_src_t;

    typedef enum logic [1:0] {
        ALU_OP_ADD    = 2'b00,
        ALU_OP_BRANCH = 2'b01,
        ALU_OP_FUNCT  = 2'b10
    } alu_op_t;

    typedef struct packed {
        imm_src_t    imm_src;
        result_src_t result_src;
        logic        mem_write;
        logic        branch;
        logic        jump;
        logic        jalr;
        logic        reg_write;
        logic        alu_src;
        alu_a_src_t  alu_a_src;
        alu_op_t     alu_op;
        logic        illegal;
    } ctrl_bundle_t;

    localparam int CTRL_W = $bits(ctrl_bundle_t);
    localparam ctrl_bundle_t CTRL_NOP = '0;

    // ID/EX keeps only what Execute and later stages consume.
    typedef struct packed {
        result_src_t result_src;
        logic        mem_write;
        logic        branch;
        logic        jump;
        logic        jalr;
        logic        reg_write;
        logic        alu_src;
        alu_a_src_t  alu_a_src;
        alu_op_t     alu_op;
    } ex_t;

    typedef struct packed {
        result_src_t result_src;
        logic        mem_write;
        logic        reg_write;
    } mem_t;

    typedef struct packed {
        result_src_t result_src;
        logic        reg_write;
    } wb_t;

    localparam ex_t  EX_NOP  = '0;
    localparam mem_t MEM_NOP = '0;
    localparam wb_t  WB_NOP  = '0;

endpackage

// File: rtl/ctrl_decode.sv
// ctrl_decode
// Purely combinational opcode decode into the control bundle.
// Ports:
//   op_code  in   7        opcode in Decode
//   ctrl     out  bundle   decoded controls; unsupported or disabled
//                          opcodes give an all-zero bundle with illegal=1
module ctrl_decode
    import ctrl_pkg::*;
#(
    parameter bit EN_JUMP  = 1'b1,
    parameter bit EN_UPPER = 1'b1
) (
    input  logic [6:0]   op_code,
    output ctrl_bundle_t ctrl
);

    always_comb begin
        ctrl = CTRL_NOP;
        case (op_code)
            OP_LOAD: begin
                ctrl.imm_src    = IMM_I;
                ctrl.result_src = RES_MEM;
                ctrl.reg_write  = 1'b1;
                ctrl.alu_src    = 1'b1;
            end
            OP_STORE: begin
                ctrl.imm_src   = IMM_S;
                ctrl.mem_write = 1'b1;
                ctrl.alu_src   = 1'b1;
            end
            OP_IMM: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.alu_op    = ALU_OP_FUNCT;
            end
            OP_BRANCH: begin
                ctrl.imm_src = IMM_B;
                ctrl.branch  = 1'b1;
                ctrl.alu_op  = ALU_OP_BRANCH;
            end
            OP_RTYPE: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_op    = ALU_OP_FUNCT;
            end
            OP_JAL, OP_JALR: begin
                if (EN_JUMP) begin
                    ctrl.result_src = RES_PC4;
                    ctrl.jump       = 1'b1;
                    ctrl.reg_write  = 1'b1;
                    ctrl.alu_src    = 1'b1;
                    // JAL targets PC+immJ; JALR targets rs1+immI.
                    if (op_code == OP_JAL) begin
                        ctrl.imm_src   = IMM_J;
                        ctrl.alu_a_src = ALU_A_PC;
                    end else begin
                        ctrl.jalr = 1'b1;
                    end
                end else begin
                    ctrl.illegal = 1'b1;
                end
            end
            OP_LUI, OP_AUIPC: begin
                if (EN_UPPER) begin
                    ctrl.imm_src   = IMM_U;
                    ctrl.reg_write = 1'b1;
                    ctrl.alu_src   = 1'b1;
                    // LUI adds the immediate to zero, AUIPC to the PC.
                    ctrl.alu_a_src = (op_code == OP_LUI) ? ALU_A_ZERO : ALU_A_PC;
                end else begin
                    ctrl.illegal = 1'b1;
                end
            end
            default: ctrl.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/ctrl_pipe_decoder.sv
// ctrl_pipe_decoder
// Decodes the opcode in Decode and carries the resulting controls through
// ID/EX, EX/MEM and MEM/WB registers; also counts valid illegal opcodes.
// Ports:
//   clk, rst_n        clock, async active-low reset (clears pipe + counter)
//   op_code_d         opcode in Decode
//   valid_d, flush_e  ID/EX loads a NOP unless valid_d=1 and flush_e=0
//   imm_src_d, illegal_d         combinational D-stage decode
//   alu_src_e .. result_src_e    Execute controls (1 cycle after D)
//   mem_write_m, reg_write_m     Memory controls  (2 cycles after D)
//   reg_write_w, result_src_w    Writeback controls (3 cycles after D)
//   ill_cnt           saturating illegal-instruction count
module ctrl_pipe_decoder #(
    parameter bit          EN_JUMP   = 1'b1,
    parameter bit          EN_UPPER  = 1'b1,
    parameter int unsigned ILL_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [6:0]           op_code_d,
    input  logic                 valid_d,
    input  logic                 flush_e,
    output logic [2:0]           imm_src_d,
    output logic                 illegal_d,
    output logic                 alu_src_e,
    output logic [1:0]           alu_a_src_e,
    output logic [1:0]           alu_op_e,
    output logic                 branch_e,
    output logic                 jump_e,
    output logic                 jalr_e,
    output logic [1:0]           result_src_e,
    output logic                 mem_write_m,
    output logic                 reg_write_m,
    output logic                 reg_write_w,
    output logic [1:0]           result_src_w,
    output logic [ILL_CNT_W-1:0] ill_cnt
);
    import ctrl_pkg::*;

    ctrl_bundle_t         ctrl_d;
    ex_t                  ex_d;
    ex_t                  ex_q;
    mem_t                 mem_q;
    wb_t                  wb_q;
    logic [ILL_CNT_W-1:0] ill_cnt_q;
    logic                 ill_inc;

    ctrl_decode #(
        .EN_JUMP  (EN_JUMP),
        .EN_UPPER (EN_UPPER)
    ) u_decode (
        .op_code (op_code_d),
        .ctrl    (ctrl_d)
    );

    always_comb begin
        ex_d = EX_NOP;
        if (valid_d && !flush_e) begin
            ex_d.result_src = ctrl_d.result_src;
            ex_d.mem_write  = ctrl_d.mem_write;
            ex_d.branch     = ctrl_d.branch;
            ex_d.jump       = ctrl_d.jump;
            ex_d.jalr       = ctrl_d.jalr;
            ex_d.reg_write  = ctrl_d.reg_write;
            ex_d.alu_src    = ctrl_d.alu_src;
            ex_d.alu_a_src  = ctrl_d.alu_a_src;
            ex_d.alu_op     = ctrl_d.alu_op;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q  <= EX_NOP;
            mem_q <= MEM_NOP;
            wb_q  <= WB_NOP;
        end else begin
            ex_q            <= ex_d;
            mem_q.result_src <= ex_q.result_src;
            mem_q.mem_write  <= ex_q.mem_write;
            mem_q.reg_write  <= ex_q.reg_write;
            wb_q.result_src  <= mem_q.result_src;
            wb_q.reg_write   <= mem_q.reg_write;
        end
    end

    // A flushed illegal opcode never executes, so it is not counted.
    assign ill_inc = valid_d && ctrl_d.illegal && !flush_e;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ill_cnt_q <= '0;
        end else if (ill_inc && (ill_cnt_q != '1)) begin
            ill_cnt_q <= ill_cnt_q + ILL_CNT_W'(1);
        end
    end

    assign imm_src_d    = ctrl_d.imm_src;
    assign illegal_d    = ctrl_d.illegal;
    assign alu_src_e    = ex_q.alu_src;
    assign alu_a_src_e  = ex_q.alu_a_src;
    assign alu_op_e     = ex_q.alu_op;
    assign branch_e     = ex_q.branch;
    assign jump_e       = ex_q.jump;
    assign jalr_e       = ex_q.jalr;
    assign result_src_e = ex_q.result_src;
    assign mem_write_m  = mem_q.mem_write;
    assign reg_write_m  = mem_q.reg_write;
    assign reg_write_w  = wb_q.reg_write;
    assign result_src_w = wb_q.result_src;
    assign ill_cnt      = ill_cnt_q;

endmodule

// File: tb/tb_ctrl_pipe_decoder.sv
// tb_ctrl_pipe_decoder
// Two instances share one stimulus stream: dut_a with default parameters,
// dut_b with EN_JUMP=0 and a 2-bit illegal counter. Stimulus pushes expected
// per-stage values, tagged with the cycle they must appear in, into a
// scoreboard; the monitor compares on each falling edge (or on demand while
// reset is asserted between edges).
module tb_ctrl_pipe_decoder;

    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] OPIMM  = 7'b0010011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] RTYPE  = 7'b0110011;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] op_code_d;
    logic       valid_d;
    logic       flush_e;

    logic [2:0] imm_src_d_a, imm_src_d_b;
    logic       illegal_d_a, illegal_d_b;
    logic       alu_src_e_a, alu_src_e_b;
    logic [1:0] alu_a_src_e_a, alu_a_src_e_b;
    logic [1:0] alu_op_e_a, alu_op_e_b;
    logic       branch_e_a, branch_e_b, jump_e_a, jump_e_b, jalr_e_a, jalr_e_b;
    logic [1:0] result_src_e_a, result_src_e_b;
    logic       mem_write_m_a, mem_write_m_b, reg_write_m_a, reg_write_m_b;
    logic       reg_write_w_a, reg_write_w_b;
    logic [1:0] result_src_w_a, result_src_w_b;
    logic [7:0] ill_cnt_a;
    logic [1:0] ill_cnt_b;

    ctrl_pipe_decoder dut_a (
        .clk(clk), .rst_n(rst_n), .op_code_d(op_code_d), .valid_d(valid_d), .flush_e(flush_e),
        .imm_src_d(imm_src_d_a), .illegal_d(illegal_d_a), .alu_src_e(alu_src_e_a),
        .alu_a_src_e(alu_a_src_e_a), .alu_op_e(alu_op_e_a), .branch_e(branch_e_a),
        .jump_e(jump_e_a), .jalr_e(jalr_e_a), .result_src_e(result_src_e_a),
        .mem_write_m(mem_write_m_a), .reg_write_m(reg_write_m_a), .reg_write_w(reg_write_w_a),
        .result_src_w(result_src_w_a), .ill_cnt(ill_cnt_a)
    );

    ctrl_pipe_decoder #(.EN_JUMP(1'b0), .EN_UPPER(1'b1), .ILL_CNT_W(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .op_code_d(op_code_d), .valid_d(valid_d), .flush_e(flush_e),
        .imm_src_d(imm_src_d_b), .illegal_d(illegal_d_b), .alu_src_e(alu_src_e_b),
        .alu_a_src_e(alu_a_src_e_b), .alu_op_e(alu_op_e_b), .branch_e(branch_e_b),
        .jump_e(jump_e_b), .jalr_e(jalr_e_b), .result_src_e(result_src_e_b),
        .mem_write_m(mem_write_m_b), .reg_write_m(reg_write_m_b), .reg_write_w(reg_write_w_b),
        .result_src_w(result_src_w_b), .ill_cnt(ill_cnt_b)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        int          kind;
        logic [15:0] val;
    } exp_t;

    typedef struct packed {
        logic [2:0] imm;
        logic [1:0] res;
        logic       mw, br, jmp, jalr, rw, asrc;
        logic [1:0] aa, aop;
        logic       ill;
    } ref_t;

    exp_t       sb[$];
    int         total = 0;
    int         bad = 0;
    event       chk_ev;
    logic [7:0] exp_cnt_a = 8'd0;
    logic [1:0] exp_cnt_b = 2'd0;

    // Hand-written decode table (EN_UPPER=1 for both instances).
    function automatic ref_t ref_dec(input logic [6:0] op, input bit en_jump);
        ref_t r;
        r = '0;
        case (op)
            LOAD:   r = '{imm:3'b000, res:2'b01, mw:1'b0, br:1'b0, jmp:1'b0, jalr:1'b0, rw:1'b1, asrc:1'b1, aa:2'b00, aop:2'b00, ill:1'b0};
            STORE:  r = '{imm:3'b001, res:2'b00, mw:1'b1, br:1'b0, jmp:1'b0, jalr:1'b0, rw:1'b0, asrc:1'b1, aa:2'b00, aop:2'b00, ill:1'b0};
            OPIMM:  r = '{imm:3'b000, res:2'b00, mw:1'b0, br:1'b0, jmp:1'b0, jalr:1'b0, rw:1'b1, asrc:1'b1, aa:2'b00, aop:2'b10, ill:1'b0};
            BRANCH: r = '{imm:3'b010, res:2'b00, mw:1'b0, br:1'b1, jmp:1'b0, jalr:1'b0, rw:1'b0, asrc:1'b0, aa:2'b00, aop:2'b01, ill:1'b0};
            RTYPE:  r = '{imm:3'b000, res:2'b00, mw:1'b0, br:1'b0, jmp:1'b0, jalr:1'b0, rw:1'b1, asrc:1'b0, aa:2'b00, aop:2'b10, ill:1'b0};
            JAL:    r = en_jump ? '{imm:3'b011, res:2'b10, mw:1'b0, br:1'b0, jmp:1'b1, jalr:1'b0, rw:1'b1, asrc:1'b1, aa:2'b10, aop:2'b00, ill:1'b0}
                                : '{imm:3'b000, res:2'b00, mw:1'b0, br:1'b0, jmp:1'b0, jalr:1'b0, rw:1'b0, asrc:1'b0, aa:2'b00, aop:2'b00, ill:1'b1};
            JALR:   r = en_jump ? '{imm:3'b000, res:2'b10, mw:1'b0, br:1'b0, jmp:1'b1, jalr:1'b1, rw:1'b1, asrc:1'b1, aa:2'b00, aop:2'b00, ill:1'b0}
                                : '{imm:3'b000, res:2'b00, mw:1'b0, br:1'b0, jmp:1'b0, jalr:1'b0, rw:1'b0, asrc:1'b0, aa:2'b00, aop:2'b00, ill:1'b1};
            LUI:    r = '{imm:3'b100, res:2'b00, mw:1'b0, br:1'b0, jmp:1'b0, jalr:1'b0, rw:1'b1, asrc:1'b1, aa:2'b01, aop:2'b00, ill:1'b0};
            AUIPC:  r = '{imm:3'b100, res:2'b00, mw:1'b0, br:1'b0, jmp:1'b0, jalr:1'b0, rw:1'b1, asrc:1'b1, aa:2'b10, aop:2'b00, ill:1'b0};
            default: r.ill = 1'b1;
        endcase
        return r;
    endfunction

    // kind: 0..4 = dut_a D/E/M/W/CNT, 5..9 = dut_b D/E/M/W/CNT
    function automatic logic [15:0] actual(input int k);
        case (k)
            0: return {12'b0, imm_src_d_a, illegal_d_a};
            1: return {6'b0, alu_src_e_a, alu_a_src_e_a, alu_op_e_a, branch_e_a, jump_e_a, jalr_e_a, result_src_e_a};
            2: return {14'b0, mem_write_m_a, reg_write_m_a};
            3: return {13'b0, reg_write_w_a, result_src_w_a};
            4: return {8'b0, ill_cnt_a};
            5: return {12'b0, imm_src_d_b, illegal_d_b};
            6: return {6'b0, alu_src_e_b, alu_a_src_e_b, alu_op_e_b, branch_e_b, jump_e_b, jalr_e_b, result_src_e_b};
            7: return {14'b0, mem_write_m_b, reg_write_m_b};
            8: return {13'b0, reg_write_w_b, result_src_w_b};
            default: return {14'b0, ill_cnt_b};
        endcase
    endfunction

    function automatic string kname(input int k);
        case (k)
            0: return "a_dstage";  1: return "a_estage";  2: return "a_mstage";
            3: return "a_wstage";  4: return "a_ill_cnt"; 5: return "b_dstage";
            6: return "b_estage";  7: return "b_mstage";  8: return "b_wstage";
            default: return "b_ill_cnt";
        endcase
    endfunction

    task automatic push(input int c, input int k, input logic [15:0] v);
        exp_t e;
        e.cyc  = c;
        e.kind = k;
        e.val  = v;
        sb.push_back(e);
    endtask

    task automatic push_dut(input int base, input ref_t r, input logic live, input logic [7:0] cnt_next);
        ref_t e;
        e = r;
        if (!live) e = '0;
        push(cyc,     base + 0, {12'b0, r.imm, r.ill});
        push(cyc + 1, base + 1, {6'b0, e.asrc, e.aa, e.aop, e.br, e.jmp, e.jalr, e.res});
        push(cyc + 2, base + 2, {14'b0, e.mw, e.rw});
        push(cyc + 3, base + 3, {13'b0, e.rw, e.res});
        push(cyc + 1, base + 4, {8'b0, cnt_next});
    endtask

    // Called at posedge+1; returns at the next posedge+1.
    task automatic issue(input logic [6:0] op, input logic v, input logic f);
        ref_t ra, rb;
        op_code_d = op;
        valid_d   = v;
        flush_e   = f;
        ra = ref_dec(op, 1'b1);
        rb = ref_dec(op, 1'b0);
        if (v && !f && ra.ill && exp_cnt_a != 8'hFF) exp_cnt_a = exp_cnt_a + 8'd1;
        if (v && !f && rb.ill && exp_cnt_b != 2'b11) exp_cnt_b = exp_cnt_b + 2'd1;
        push_dut(0, ra, v && !f, exp_cnt_a);
        push_dut(5, rb, v && !f, {6'b0, exp_cnt_b});
        @(posedge clk);
        #1;
    endtask

    // While in reset every registered output and both counters must be zero;
    // the D-stage decode of the current opcode must still be visible.
    task automatic push_reset_zeros();
        ref_t ra, rb;
        ra = ref_dec(op_code_d, 1'b1);
        rb = ref_dec(op_code_d, 1'b0);
        push(cyc, 0, {12'b0, ra.imm, ra.ill});
        push(cyc, 5, {12'b0, rb.imm, rb.ill});
        for (int k = 1; k <= 4; k++) begin
            push(cyc, k, 16'h0000);
            push(cyc, k + 5, 16'h0000);
        end
    endtask

    // Monitor
    initial begin : monitor
        logic [15:0] act;
        forever begin
            @(negedge clk or chk_ev);
            for (int i = sb.size() - 1; i >= 0; i--) begin
                if (sb[i].cyc == cyc) begin
                    total++;
                    act = actual(sb[i].kind);
                    if (act !== sb[i].val) begin
                        bad++;
                        $display("FAIL %s cyc=%0d actual=%h required=%h", kname(sb[i].kind), cyc, act, sb[i].val);
                    end
                    sb.delete(i);
                end else if (sb[i].cyc < cyc) begin
                    total++;
                    bad++;
                    $display("FAIL %s missed cyc=%0d actual=none required=%h", kname(sb[i].kind), sb[i].cyc, sb[i].val);
                    sb.delete(i);
                end
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        rst_n     = 1'b0;
        op_code_d = 7'b0000000;
        valid_d   = 1'b0;
        flush_e   = 1'b0;
        #2;
        push_reset_zeros();
        #1 -> chk_ev;
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Illegal burst: dut_b 2-bit counter goes 1,2,3,3,3
        issue(7'b0000000, 1'b1, 1'b0);
        issue(7'b1111111, 1'b1, 1'b0);
        issue(7'b0001000, 1'b1, 1'b0);
        issue(7'b1111111, 1'b1, 1'b0);
        issue(7'b0000000, 1'b1, 1'b0);

        issue(LOAD,  1'b1, 1'b0);
        issue(STORE, 1'b1, 1'b0);
        issue(RTYPE, 1'b1, 1'b0);

        // R-type now sits in E: assert reset between edges.
        @(negedge clk);
        #2 rst_n = 1'b0;
        for (int i = sb.size() - 1; i >= 0; i--)
            if (sb[i].cyc > cyc) sb.delete(i);
        exp_cnt_a = 8'd0;
        exp_cnt_b = 2'd0;
        push_reset_zeros();
        #1 -> chk_ev;
        @(posedge clk);
        #1;
        push_reset_zeros();
        @(negedge clk);
        #2;
        valid_d = 1'b0;
        rst_n   = 1'b1;
        @(posedge clk);
        #1;

        issue(BRANCH, 1'b1, 1'b1);
        issue(OPIMM,  1'b1, 1'b0);
        issue(LUI,    1'b1, 1'b0);
        issue(AUIPC,  1'b1, 1'b0);
        issue(JALR,   1'b1, 1'b0);
        issue(JAL,    1'b1, 1'b0);
        issue(LOAD,   1'b0, 1'b0);
        issue(7'b1111111, 1'b1, 1'b1);
        issue(BRANCH, 1'b1, 1'b0);
        issue(JAL,    1'b1, 1'b0);
        issue(STORE,  1'b1, 1'b0);

        valid_d = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        #1;
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL drain actual=%0d_pending required=0_pending", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
